hasti_uart_loader: RTL and testbench

//  UART-driven HASTI bus master (initiator) for loading memory over RS-232 without the core.

---
 rtl/hasti_uart_loader_pkg.sv | 52 +++++
 rtl/hasti_uart_loader_if.sv | 24 ++
 rtl/hasti_uart_loader_uart_rx.sv | 111 +++++++++++
 rtl/hasti_uart_loader.sv | 178 +++++++++++++++++
 tb/tb_hasti_uart_loader.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hasti_uart_loader_pkg.sv
// Shared types and constants for the UART-driven HASTI loader: bus encodings,
// command byte and FSM state enums.
package hasti_uart_loader_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1
  } hburst_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  localparam logic [3:0] HPROT_DATA = 4'b0011;
  localparam logic [7:0] CMD_WRITE  = 8'h57;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_ADDR,
    P_DATA,
    P_BUS_A,
    P_BUS_D
  } pkt_state_t;

  // Rounded clock cycles per UART bit.
  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/hasti_uart_loader_if.sv
// HASTI (AHB-lite) single-master bus bundle used between the loader and its target.
interface hasti_uart_loader_if;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/hasti_uart_loader_uart_rx.sv
// 8N1 UART receiver: synchronises rxd, samples mid-bit and emits one-cycle
// byte_valid or frame_err pulses.
module uart_rx
  import hasti_uart_loader_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 174
) (
  input  logic       hclk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);

  logic            rxd_p0, rxd_p1, rxd_p2;
  logic            fall;
  rx_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            byte_valid_d, frame_err_d;

  // Synchroniser stages; p2 is kept only to detect the falling edge.
  always_ff @(posedge hclk) begin
    if (reset) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  // Edge-triggered start also covers the wait-for-high after a framing error.
  assign fall = rxd_p2 & ~rxd_p1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rxd_p1 ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxd_p1, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          state_d      = RX_IDLE;
          byte_valid_d = rxd_p1;
          frame_err_d  = ~rxd_p1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_valid <= byte_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  always_ff @(posedge hclk) begin
    shreg_q <= shreg_d;
  end

  assign byte_data = shreg_q;

endmodule

// File: rtl/hasti_uart_loader.sv
// UART command-packet loader acting as a HASTI master: 'W' + addr + data
// (little-endian) becomes one single-word write.
module hasti_uart_loader
  import hasti_uart_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 20_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic                hclk,
  input  logic                reset,
  input  logic                rxd,
  hasti_uart_loader_if.master bus,
  output logic                busy,
  output logic [3:0]          loader_err,
  output logic [15:0]         words_cnt
);

  localparam int unsigned BIT_CYCLES     = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BITS * BIT_CYCLES;
  localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  logic [7:0]      byte_data;
  logic            byte_valid, frame_err;
  logic            hold_full_q;
  logic [7:0]      hold_data_q;
  logic            pop, load, overrun;
  pkt_state_t      pkt_q, pkt_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0] to_cnt_q;
  logic            timeout;
  logic [31:0]     addr_sr, data_sr;
  logic [31:0]     haddr_q, hwdata_q;
  logic            align_set, bus_ok, bus_fail;
  htrans_t         htrans_c;
  logic            hwrite_c;
  logic            hrdata_unused;

  uart_rx #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
    .hclk       (hclk),
    .reset      (reset),
    .rxd        (rxd),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  // Holding register: bytes are consumed only while the packet FSM is assembling.
  assign pop     = hold_full_q && (pkt_q == P_IDLE || pkt_q == P_ADDR || pkt_q == P_DATA);
  assign load    = byte_valid && (!hold_full_q || pop);
  assign overrun = byte_valid && hold_full_q && !pop;

  always_ff @(posedge hclk) begin
    if (reset)     hold_full_q <= 1'b0;
    else if (load) hold_full_q <= 1'b1;
    else if (pop)  hold_full_q <= 1'b0;
  end

  always_ff @(posedge hclk) begin
    if (load) hold_data_q <= byte_data;
  end

  assign timeout = (to_cnt_q == TO_LAST);

  always_comb begin
    pkt_d      = pkt_q;
    byte_cnt_d = byte_cnt_q;
    align_set  = 1'b0;
    bus_ok     = 1'b0;
    bus_fail   = 1'b0;
    htrans_c   = HTRANS_IDLE;
    hwrite_c   = 1'b0;
    unique case (pkt_q)
      P_IDLE: begin
        if (pop && hold_data_q == CMD_WRITE) begin
          pkt_d      = P_ADDR;
          byte_cnt_d = '0;
        end
      end
      P_ADDR: begin
        if (pop) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) pkt_d = P_DATA;
        end else if (timeout) begin
          pkt_d = P_IDLE;
        end
      end
      P_DATA: begin
        if (pop) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (addr_sr[1:0] != 2'b00) begin
              align_set = 1'b1;
              pkt_d     = P_IDLE;
            end else begin
              pkt_d = P_BUS_A;
            end
          end
        end else if (timeout) begin
          pkt_d = P_IDLE;
        end
      end
      P_BUS_A: begin
        htrans_c = HTRANS_NONSEQ;
        hwrite_c = 1'b1;
        if (bus.hready) pkt_d = P_BUS_D;
      end
      P_BUS_D: begin
        if (bus.hready) begin
          pkt_d    = P_IDLE;
          bus_fail = (bus.hresp == HRESP_ERROR);
          bus_ok   = (bus.hresp != HRESP_ERROR);
        end
      end
      default: pkt_d = P_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      pkt_q      <= P_IDLE;
      byte_cnt_q <= '0;
    end else begin
      pkt_q      <= pkt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Timeout measures idle time since the last byte of an open packet.
  always_ff @(posedge hclk) begin
    if (reset)
      to_cnt_q <= '0;
    else if ((pkt_q == P_ADDR || pkt_q == P_DATA) && !pop)
      to_cnt_q <= to_cnt_q + TO_W'(1);
    else
      to_cnt_q <= '0;
  end

  // First byte received lands in bits [7:0].
  always_ff @(posedge hclk) begin
    if (pop && pkt_q == P_ADDR) addr_sr <= {hold_data_q, addr_sr[31:8]};
    if (pop && pkt_q == P_DATA) data_sr <= {hold_data_q, data_sr[31:8]};
  end

  // Address and write data are latched at phase entry so they stay put through stalls.
  always_ff @(posedge hclk) begin
    if (reset) begin
      haddr_q  <= '0;
      hwdata_q <= '0;
    end else begin
      if (pkt_q == P_DATA && pkt_d == P_BUS_A)  haddr_q  <= addr_sr;
      if (pkt_q == P_BUS_A && pkt_d == P_BUS_D) hwdata_q <= data_sr;
    end
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      loader_err <= '0;
      words_cnt  <= '0;
    end else begin
      loader_err <= loader_err | {bus_fail, align_set, overrun, frame_err};
      if (bus_ok) words_cnt <= words_cnt + 16'd1;
    end
  end

  assign busy          = (pkt_q != P_IDLE);
  assign bus.haddr     = haddr_q;
  assign bus.hwdata    = hwdata_q;
  assign bus.htrans    = htrans_c;
  assign bus.hwrite    = hwrite_c;
  assign bus.hsize     = HSIZE_WORD;
  assign bus.hburst    = HBURST_SINGLE;
  assign bus.hmastlock = 1'b0;
  assign bus.hprot     = HPROT_DATA;
  assign hrdata_unused = ^bus.hrdata;

endmodule

// File: tb/tb_hasti_uart_loader.sv
// Directed bench for hasti_uart_loader: table of packets against a stalling
// HASTI slave, plus hand sequences for framing, timeout, back-to-back and reset.
module tb_hasti_uart_loader;

  localparam int BITC = 16;  // (1_600_000 + 50_000) / 100_000

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        busy;
  logic [3:0]  loader_err;
  logic [15:0] words_cnt;

  hasti_uart_loader_if bus();

  hasti_uart_loader #(
    .CLK_FREQ     (1_600_000),
    .BAUD         (100_000),
    .TIMEOUT_BITS (32)
  ) dut (
    .hclk       (clk),
    .reset      (rst),
    .rxd        (rxd),
    .bus        (bus),
    .busy       (busy),
    .loader_err (loader_err),
    .words_cnt  (words_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    logic        err;
    logic        exp_wr;
    logic [3:0]  exp_flags;
    logic [15:0] exp_words;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        resp;
  } wr_t;

  vec_t vecs[5];
  wr_t  wlog[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_n = 0;
  logic err_mode = 1'b0;
  int   stab_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model: decides hready each cycle, logs completed writes, watches stability.
  initial begin : slave
    logic        dphase, hold_a, hold_d;
    logic [31:0] save_a, save_d, dp_addr;
    int          wcnt;
    dphase = 1'b0; hold_a = 1'b0; hold_d = 1'b0; wcnt = 0;
    save_a = '0; save_d = '0; dp_addr = '0;
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    bus.hrdata = '0;
    forever begin
      @(negedge clk);
      if (hold_a && (bus.htrans !== 2'd2 || bus.haddr !== save_a || bus.hwrite !== 1'b1)) stab_bad++;
      if (hold_d && bus.hwdata !== save_d) stab_bad++;
      if (dphase || bus.htrans == 2'd2) begin
        if (wcnt < stall_n) begin
          bus.hready = 1'b0;
          wcnt++;
        end else begin
          bus.hready = 1'b1;
          wcnt = 0;
        end
      end else begin
        bus.hready = 1'b1;
        wcnt = 0;
      end
      bus.hresp = (dphase && bus.hready) ? err_mode : 1'b0;
      hold_a = !bus.hready && !dphase && bus.htrans == 2'd2;
      hold_d = !bus.hready && dphase;
      save_a = bus.haddr;
      save_d = bus.hwdata;
      if (bus.hready && dphase) begin
        wlog.push_back(wr_t'{dp_addr, bus.hwdata, bus.hresp});
        dphase = 1'b0;
      end else if (bus.hready && bus.htrans == 2'd2) begin
        dp_addr = bus.haddr;
        dphase  = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BITC) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BITC) @(negedge clk);
    if (!stop_bit) begin
      rxd = 1'b1;
      repeat (BITC) @(negedge clk);
    end
  endtask

  task automatic send_pkt(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] av, dv;
    av = a;
    dv = d;
    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(av[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(dv[8*i +: 8], 1'b1);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("busy_drop", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_htrans"}, {30'd0, bus.htrans}, 32'd0);
    check({tag, "_hwrite"}, {31'd0, bus.hwrite}, 32'd0);
    check({tag, "_haddr"}, bus.haddr, 32'd0);
    check({tag, "_hwdata"}, bus.hwdata, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {28'd0, loader_err}, 32'd0);
    check({tag, "_words"}, {16'd0, words_cnt}, 32'd0);
  endtask

  initial begin : main
    int base;
    vecs[0] = '{32'h0001_0000, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 4'b0000, 16'd1};
    vecs[1] = '{32'h0001_0000, 32'hDEAD_BEEF, 3, 1'b0, 1'b1, 4'b0000, 16'd2};
    vecs[2] = '{32'h0000_0002, 32'h1234_5678, 0, 1'b0, 1'b0, 4'b0100, 16'd2};
    vecs[3] = '{32'h2000_0010, 32'hCAFE_F00D, 1, 1'b1, 1'b1, 4'b1100, 16'd2};
    vecs[4] = '{32'h0000_FFFC, 32'hA5A5_5A5A, 0, 1'b0, 1'b1, 4'b1100, 16'd3};

    rxd = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    for (int v = 0; v < 5; v++) begin
      stall_n  = vecs[v].stall;
      err_mode = vecs[v].err;
      base     = wlog.size();
      send_pkt(vecs[v].addr, vecs[v].data);
      wait_idle(300);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_wr_count", v), wlog.size() - base, vecs[v].exp_wr ? 32'd1 : 32'd0);
      if (vecs[v].exp_wr && wlog.size() > base) begin
        check($sformatf("v%0d_addr", v), wlog[base].addr, vecs[v].addr);
        check($sformatf("v%0d_data", v), wlog[base].data, vecs[v].data);
      end
      check($sformatf("v%0d_flags", v), {28'd0, loader_err}, {28'd0, vecs[v].exp_flags});
      check($sformatf("v%0d_words", v), {16'd0, words_cnt}, {16'd0, vecs[v].exp_words});
    end
    check("hsize", {29'd0, bus.hsize}, 32'd2);
    check("hburst", {29'd0, bus.hburst}, 32'd0);
    check("hprot", {28'd0, bus.hprot}, 32'd3);
    check("hmastlock", {31'd0, bus.hmastlock}, 32'd0);

    // Framing error on the 3rd byte, then the packet must time out.
    stall_n  = 0;
    err_mode = 1'b0;
    base     = wlog.size();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b0);
    check("ferr_flag", {28'd0, loader_err}, 32'b1101);
    check("ferr_busy_hold", {31'd0, busy}, 32'd1);
    repeat (250) @(negedge clk);
    check("ferr_busy_before_to", {31'd0, busy}, 32'd1);
    repeat (200) @(negedge clk);
    check("ferr_busy_after_to", {31'd0, busy}, 32'd0);
    check("ferr_no_write", wlog.size() - base, 32'd0);
    send_pkt(32'h0000_0100, 32'h0BAD_F00D);
    wait_idle(300);
    repeat (4) @(negedge clk);
    check("post_ferr_count", wlog.size() - base, 32'd1);
    if (wlog.size() > base) check("post_ferr_data", wlog[base].data, 32'h0BAD_F00D);
    check("post_ferr_words", {16'd0, words_cnt}, 32'd4);

    // Non-command bytes while idle are ignored.
    base = wlog.size();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    check("zero_busy", {31'd0, busy}, 32'd0);
    send_pkt(32'h0000_0200, 32'h00C0_FFEE);
    wait_idle(300);
    repeat (4) @(negedge clk);
    check("zero_count", wlog.size() - base, 32'd1);
    if (wlog.size() > base) check("zero_addr", wlog[base].addr, 32'h0000_0200);
    check("zero_words", {16'd0, words_cnt}, 32'd5);

    // Back-to-back packets with long stalls.
    stall_n = 20;
    base    = wlog.size();
    for (int p = 0; p < 3; p++) send_pkt(32'h40 + 32'(4 * p), {4{8'(8'h11 * (p + 1))}});
    wait_idle(300);
    repeat (4) @(negedge clk);
    check("b2b_count", wlog.size() - base, 32'd3);
    for (int p = 0; p < 3; p++) begin
      if (wlog.size() > base + p) begin
        check($sformatf("b2b%0d_addr", p), wlog[base+p].addr, 32'h40 + 32'(4 * p));
        check($sformatf("b2b%0d_data", p), wlog[base+p].data, {4{8'(8'h11 * (p + 1))}});
      end
    end
    check("b2b_flags", {28'd0, loader_err}, 32'b1101);
    check("b2b_words", {16'd0, words_cnt}, 32'd8);
    check("bus_stable", stab_bad, 32'd0);

    // Reset in the middle of a packet.
    stall_n = 2;
    send_byte(8'h57, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("mid_busy", {31'd0, busy}, 32'd1);
    do_reset();
    check_reset_state("midrst");
    base = wlog.size();
    send_pkt(32'h0000_0300, 32'h600D_CAFE);
    wait_idle(300);
    repeat (4) @(negedge clk);
    check("rst_count", wlog.size() - base, 32'd1);
    if (wlog.size() > base) check("rst_data", wlog[base].data, 32'h600D_CAFE);
    check("rst_words", {16'd0, words_cnt}, 32'd1);
    check("rst_flags", {28'd0, loader_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
